fetch_unit: RTL and testbench

Instruction-fetch controller that reads the current PC and computes the next one. It drives the PC register's write port (next_pc / isPCWrite) and runs a req/ack handshake to instruction memory, which may insert wait states. It also owns the IF/ID pipeline register, including a one-entry hold buffer for decode stalls. It applies branch/jump redirects, including redirects that arrive while a fetch is still in flight.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_unit_ifid_hold_buf.sv | 39 +++
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch block
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_ifid_hold_buf.sv
// rtl/fetch_unit_ifid_hold_buf.sv - one-entry skid buffer catching a fetched word while decode is stalled
module ifid_hold_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_release,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc4,
    output logic        o_full
);

    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_full;

    always_ff @(posedge clk) begin
        if (i_rst || i_flush) begin
            r_full  <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'd0;
        end else if (i_load) begin
            r_full  <= 1'b1;
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
        end else if (i_release) begin
            r_full  <= 1'b0;
        end
    end

    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;
    assign o_full  = r_full;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch FSM, next-PC mux and IF/ID register with redirect and wait-state handling
module fetch_unit
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        PCReSet,
    input  logic [31:0] PC,
    output logic [31:0] next_pc,
    output logic        isPCWrite,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        stall_id,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid
);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_drain_addr, r_pend_target;
    logic [31:0] r_ifid_instr, r_ifid_pc4;
    logic        r_ifid_valid, r_was_rst;

    logic        w_redir, w_buf_load, w_buf_release, w_buf_flush, w_buf_full;
    logic [31:0] w_target, w_pc4, w_buf_instr, w_buf_pc4;

    assign w_redir  = branch_taken | jump;
    assign w_target = branch_taken ? branch_target : jump_target;
    assign w_pc4    = PC + 32'd4;

    ifid_hold_buf u_hold (
        .clk       (clk),
        .i_rst     (PCReSet),
        .i_load    (w_buf_load),
        .i_release (w_buf_release),
        .i_flush   (w_buf_flush),
        .i_instr   (imem_rdata),
        .i_pc4     (w_pc4),
        .o_instr   (w_buf_instr),
        .o_pc4     (w_buf_pc4),
        .o_full    (w_buf_full)
    );

    always_ff @(posedge clk) begin
        if (PCReSet) r_state <= S_REQ;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_REQ: begin
                if (!imem_ack && w_redir)                   w_state_nxt = S_DRAIN;
                else if (imem_ack && !w_redir && stall_id)  w_state_nxt = S_HOLD;
            end
            S_HOLD:  if (w_redir || !stall_id) w_state_nxt = S_REQ;
            S_DRAIN: if (imem_ack)             w_state_nxt = S_REQ;
            default: w_state_nxt = S_REQ;
        endcase
    end

    // A drain keeps presenting the abandoned address until memory completes it
    always_comb begin
        imem_req      = !PCReSet && (r_state != S_HOLD);
        imem_addr     = (r_state == S_DRAIN) ? r_drain_addr : PC;
        isPCWrite     = 1'b0;
        next_pc       = w_pc4;
        w_buf_load    = 1'b0;
        w_buf_release = 1'b0;
        w_buf_flush   = 1'b0;
        if (!PCReSet) begin
            case (r_state)
                S_REQ: begin
                    isPCWrite  = imem_ack;
                    next_pc    = w_redir ? w_target : w_pc4;
                    w_buf_load = imem_ack && !w_redir && stall_id;
                end
                S_HOLD: begin
                    isPCWrite     = w_redir;
                    next_pc       = w_target;
                    w_buf_flush   = w_redir;
                    w_buf_release = !w_redir && !stall_id;
                end
                S_DRAIN: begin
                    isPCWrite = imem_ack;
                    next_pc   = w_redir ? w_target : r_pend_target;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        r_was_rst <= PCReSet;
        if (PCReSet) begin
            r_ifid_valid  <= 1'b0;
            r_ifid_instr  <= NOP_INSTR;
            r_ifid_pc4    <= 32'd0;
            r_pend_target <= 32'd0;
            r_drain_addr  <= 32'd0;
        end else if (w_redir) begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= NOP_INSTR;
            if (r_state == S_DRAIN || (r_state == S_REQ && !imem_ack))
                r_pend_target <= w_target;
            if (r_state == S_REQ && !imem_ack)
                r_drain_addr <= PC;
        end else if (r_state == S_REQ) begin
            if (imem_ack && !stall_id) begin
                r_ifid_valid <= 1'b1;
                r_ifid_instr <= imem_rdata;
                r_ifid_pc4   <= w_pc4;
            end else if (!imem_ack && !stall_id) begin
                r_ifid_valid <= 1'b0;
            end
        end else if (r_state == S_HOLD && !stall_id) begin
            r_ifid_valid <= 1'b1;
            r_ifid_instr <= w_buf_instr;
            r_ifid_pc4   <= w_buf_pc4;
        end
    end

    always_ff @(posedge clk) begin
        if (!PCReSet && r_state == S_HOLD)
            assert (w_buf_full);
        if (r_was_rst && !PCReSet)
            assert (PC == RESET_PC);
    end

    assign ifid_instr = r_ifid_instr;
    assign ifid_pc4   = r_ifid_pc4;
    assign ifid_valid = r_ifid_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized bench for fetch_unit against a behavioural fetch model
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        PCReSet = 1'b1;
    logic [31:0] PC = 32'h0000_3000;
    logic [31:0] next_pc;
    logic        isPCWrite;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_ack = 1'b0;
    logic        stall_id = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'd0;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .PCReSet(PCReSet), .PC(PC), .next_pc(next_pc), .isPCWrite(isPCWrite),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .stall_id(stall_id), .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // PC register and memory kept by the bench
    logic [31:0] pc_q = 32'h0000_3000;
    int mem_cnt = 0, mem_wait = 0, wait_lo = 0, wait_hi = 0;

    // Behavioural view: a word may be parked waiting for decode, or a cancelled fetch may be draining
    bit          m_parked, m_draining, m_ifv;
    logic [31:0] m_park_instr, m_park_pc4, m_pend, m_drain_addr, m_ifi, m_ifp4;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit rst, input bit stl, input bit br, input logic [31:0] bt,
                         input bit jp, input logic [31:0] jt);
        bit          ack_now, redir, exp_rq, exp_wr;
        logic [31:0] tgt, exp_np, exp_addr, rdata;
        @(negedge clk);
        PCReSet = rst; stall_id = stl; branch_taken = br; branch_target = bt;
        jump = jp; jump_target = jt; PC = pc_q; imem_ack = 1'b0;
        #1;
        ack_now = !rst && imem_req && (mem_cnt >= mem_wait);
        rdata = ack_now ? word_of(imem_addr) : 32'hDEAD_BEEF;
        imem_ack = ack_now; imem_rdata = rdata;
        #1;
        redir    = br || jp;
        tgt      = br ? bt : jt;
        exp_rq   = !rst && !m_parked;
        exp_addr = m_draining ? m_drain_addr : pc_q;
        exp_wr   = !rst && (m_parked ? redir : ack_now);
        exp_np   = (m_parked || redir) ? tgt : (m_draining ? m_pend : pc_q + 32'd4);
        chk("imem_req", {31'd0, imem_req}, {31'd0, exp_rq});
        if (exp_rq) chk("imem_addr", imem_addr, exp_addr);
        chk("isPCWrite", {31'd0, isPCWrite}, {31'd0, exp_wr});
        if (exp_wr) chk("next_pc", next_pc, exp_np);
        chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_ifv});
        chk("ifid_instr", ifid_instr, m_ifi);
        chk("ifid_pc4", ifid_pc4, m_ifp4);
        if (rst) begin
            m_parked = 0; m_draining = 0; m_ifv = 0; m_ifi = 32'd0; m_ifp4 = 32'd0;
            m_pend = 32'd0; pc_q = 32'h0000_3000;
        end else begin
            if (redir) begin m_ifv = 0; m_ifi = 32'd0; end
            if (m_draining) begin
                if (redir) m_pend = tgt;
                if (ack_now) m_draining = 0;
            end else if (m_parked) begin
                if (redir) m_parked = 0;
                else if (!stl) begin
                    m_parked = 0; m_ifv = 1; m_ifi = m_park_instr; m_ifp4 = m_park_pc4;
                end
            end else if (ack_now) begin
                if (!redir && !stl) begin m_ifv = 1; m_ifi = rdata; m_ifp4 = pc_q + 32'd4; end
                else if (!redir) begin m_parked = 1; m_park_instr = rdata; m_park_pc4 = pc_q + 32'd4; end
            end else if (redir) begin
                m_draining = 1; m_drain_addr = pc_q; m_pend = tgt;
            end else if (!stl) m_ifv = 0;
            if (exp_wr) pc_q = exp_np;
        end
        if (rst || ack_now) begin
            mem_cnt = 0; mem_wait = $urandom_range(wait_hi, wait_lo);
        end else if (imem_req) mem_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 32'd0, 0, 32'd0);
    endtask

    task automatic set_wait(input int lo, input int hi);
        wait_lo = lo; wait_hi = hi;
    endtask

    initial begin
        // zero-wait streaming from reset
        set_wait(0, 0);
        cycle(1, 0, 0, 32'd0, 0, 32'd0);
        cycle(1, 0, 0, 32'd0, 0, 32'd0);
        chk("reset_valid", {31'd0, ifid_valid}, 32'd0);
        run(3);
        chk("pc_after_3", pc_q, 32'h0000_300C);
        chk("ifid_pc4_seq", ifid_pc4, 32'h0000_3008);
        // two wait states
        set_wait(2, 2);
        run(9);
        // decode stall while a word is returned
        set_wait(0, 0);
        cycle(1, 0, 0, 32'd0, 0, 32'd0);
        run(1);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 32'd0, 0, 32'd0);
        chk("hold_pc", pc_q, 32'h0000_3008);
        run(3);
        // branch on an ack cycle, then branch and jump together
        cycle(0, 0, 1, 32'h0000_3100, 0, 32'd0);
        run(2);
        cycle(0, 0, 1, 32'h0000_3200, 1, 32'h0000_3400);
        run(1);
        chk("branch_wins", pc_q, 32'h0000_3204);
        // jump one cycle into a 3-wait fetch, then an overriding redirect during the drain
        set_wait(3, 3);
        run(4);
        run(1);
        cycle(0, 0, 0, 32'd0, 1, 32'h0000_3400);
        run(4);
        run(1);
        cycle(0, 0, 0, 32'd0, 1, 32'h0000_3500);
        cycle(0, 0, 1, 32'h0000_3600, 0, 32'd0);
        run(4);
        // reset while draining
        run(1);
        cycle(0, 0, 0, 32'd0, 1, 32'h0000_3700);
        cycle(1, 0, 0, 32'd0, 0, 32'd0);
        run(5);
        // wrap of PC+4 at the top of the address space
        set_wait(0, 1);
        cycle(0, 0, 0, 32'd0, 1, 32'hFFFF_FFFC);
        run(6);
        // random traffic
        set_wait(0, 3);
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(99, 0) == 0), ($urandom_range(9, 0) < 3),
                  ($urandom_range(9, 0) == 0), $urandom & 32'hFFFF_FFFC,
                  ($urandom_range(9, 0) == 0), $urandom & 32'hFFFF_FFFC);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
